hamming_secded_stream: RTL
==========================

# hamming_secded_stream

- Parametrised, pipelined SECDED (single-error-correct, double-error-detect) Hamming decoder with a valid/ready stream interface.
- Generalises the fixed combinational Hamming decoder in three ways: any data width, an extra overall-parity bit for double-error detection, and saturating error counters.
- Sits between a coded-data source (memory/channel model) and downstream consumers, and accepts one codeword per cycle under backpressure.

## Interface

Parameters:
- DATA_W, default 8: data bits per word; legal range 4..57.
- CNT_W, default 16: width of each error counter.
- Derived (localparam) P: smallest integer with 2^P >= DATA_W+P+1.
- Derived (localparam) CODE_W = DATA_W+P+1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  block can accept in_code this cycle.
- in_code  in  CODE_W  received codeword.
- out_valid  out  1  out_data and out_err are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_data  out  DATA_W  corrected data.
- out_err  out  2  word status: 00 clean, 01 single error corrected, 10 uncorrectable, 11 never driven.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of transferred words with out_err=01, saturating.
- uncorr_cnt  out  CNT_W  count of transferred words with out_err=10, saturating.

## Operation

Codeword bit mapping:
- Hamming position p (1..CODE_W-1) is in_code[CODE_W-p], so position 1 is the MSB.
- in_code[0] is the overall even-parity bit, covering all CODE_W bits.
- Check bits sit at the power-of-two positions.
- Data bits sit at the remaining positions; the lowest data position (3) maps to out_data MSB, and data continues in ascending position order.

Checks computed per word:
- Syndrome S (P bits): bit i is the XOR of all positions with bit i set.
- Q: XOR of all CODE_W bits.

Classification:
- S=0, Q=0: out_err=00; data unchanged.
- Q=1, S=0: out_err=01; the error is in the overall-parity bit, so data is unchanged.
- Q=1, 1<=S<=CODE_W-1: invert position S, then extract data; out_err=01.
- Q=1, S>CODE_W-1 (out of range): out_err=10; data extracted uncorrected.
- Q=0, S!=0: out_err=10; data extracted uncorrected.

Pipeline:
- Stage 1 registers the codeword, S and Q. Stage 2 registers out_data and out_err.
- s2_adv = !out_valid || out_ready.
- s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv; this is a combinational path from out_ready.
- Transfer rules: a word is accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
- A stalled stage holds its data and valid; no word is dropped or duplicated.

Counters:
- Update only on an output transfer; they saturate at 2^CNT_W-1.
- clr_cnt has priority: it zeroes both counters, including a transfer in the same cycle, so that word is not counted.

## Timing

- Reset (rst=1 at a clock edge): out_valid=0, stage-1 valid=0, out_data=0, out_err=00, corr_cnt=0, uncorr_cnt=0.
- in_ready is 1 in the first cycle after reset is released.
- Reset mid-operation discards all in-flight words.
- Latency: a word accepted at edge k shows out_valid=1 after edge k+1 if the pipe is empty, i.e. 2 register stages.
- Throughput: 1 word per cycle while out_ready=1.
- Full pipe with out_ready=0: in_ready=0 in that same cycle, and both stages hold.
- Simultaneous events: out_ready=1 with a full pipe lets a new input be accepted in the same cycle as the output transfer.
- Outputs are registered; only in_ready is combinational.

## Test plan

All scenarios use DATA_W=8, so P=4 and CODE_W=13.

- Clean word: in_code=13'h0000 -> out_data=8'h00, out_err=00, corr_cnt and uncorr_cnt stay 0, out_valid rises 2 edges after acceptance.
- Single-error correction:
  - 13'h0400 (position 3 flipped) -> out_data=8'h00, out_err=01, corr_cnt=1.
  - 13'h0001 (parity bit flipped) -> out_data=8'h00, out_err=01.
- Double error: 13'h0500 (positions 3 and 5 flipped) -> out_data=8'hC0 (uncorrected), out_err=10, uncorr_cnt increments.
- Out-of-range syndrome: 13'h1220 (positions 1, 4, 8; S=13, Q=1) -> out_data=8'h00, out_err=10.
- Backpressure:
  - Stream 4 words with out_ready=0 -> in_ready drops after 2 accepts.
  - Raise out_ready -> all 4 words appear in order with no loss or duplication.
- Counters and reset:
  - With CNT_W=2, send 5 single-error words -> corr_cnt sticks at 3.
  - Assert clr_cnt together with a transfer -> both counters read 0.
  - Assert rst with a full pipe -> out_valid=0 the next cycle, and no stale word is emitted afterwards.

Source files
------------

// File: rtl/hamming_secded_stream.sv
// hamming_secded_stream
//   Two-stage pipelined SECDED Hamming decoder with a valid/ready stream
//   interface and saturating error counters.
//
//   Ports:
//     clk, rst              rising-edge clock, synchronous active-high reset
//     in_valid/in_ready     input handshake; in_ready is combinational from out_ready
//     in_code[CODE_W-1:0]   received codeword (Hamming position p at bit CODE_W-p,
//                           overall even parity at bit 0)
//     out_valid/out_ready   output handshake
//     out_data[DATA_W-1:0]  corrected data
//     out_err[1:0]          00 clean, 01 single error corrected, 10 uncorrectable
//     clr_cnt               zero both counters (wins over a same-cycle transfer)
//     corr_cnt, uncorr_cnt  saturating counts of delivered 01 / 10 words
module hamming_secded_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  // Smallest P with 2^P >= DATA_W+P+1, written out for the legal 4..57 range
  localparam int P      = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_err,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Hamming position of the j-th data bit (j=0 lands on out_data MSB)
  function automatic int data_pos(input int j);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int p = 3; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == j) r = p;
        n++;
      end
    end
    return r;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [P-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_err_q, out_err_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

  logic              s1_adv, s2_adv, in_fire, out_fire;
  logic [P-1:0]      syn;
  logic [CODE_W-1:0] fixed_code;
  logic [DATA_W-1:0] ext_data;
  logic [1:0]        err;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && s1_adv;
  assign out_fire = out_valid_q && out_ready;

  // Syndrome bit i folds in every position whose index has bit i set
  always_comb begin
    syn = '0;
    for (int p = 1; p < CODE_W; p++)
      for (int i = 0; i < P; i++)
        if (((p >> i) & 1) == 1) syn[i] = syn[i] ^ in_code[CODE_W-p];
  end

  // Flip the bit the syndrome points at; only a single error (odd overall
  // parity) with an in-range syndrome is trusted.
  always_comb begin
    fixed_code = s1_code_q;
    for (int p = 1; p < CODE_W; p++)
      if (s1_par_q && int'(s1_syn_q) == p)
        fixed_code[CODE_W-p] = ~fixed_code[CODE_W-p];
  end

  always_comb begin
    if (s1_syn_q == '0)                               err = s1_par_q ? 2'b01 : 2'b00;
    else if (s1_par_q && int'(s1_syn_q) <= CODE_W-1)  err = 2'b01;
    else                                              err = 2'b10;
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_ext
    assign ext_data[DATA_W-1-j] = fixed_code[CODE_W-data_pos(j)];
  end

  always_comb begin
    s1_valid_d   = s1_adv ? in_valid : s1_valid_q;
    s1_code_d    = in_fire ? in_code : s1_code_q;
    s1_syn_d     = in_fire ? syn : s1_syn_q;
    s1_par_d     = in_fire ? ^in_code : s1_par_q;
    out_valid_d  = s2_adv ? s1_valid_q : out_valid_q;
    out_data_d   = (s2_adv && s1_valid_q) ? ext_data : out_data_q;
    out_err_d    = (s2_adv && s1_valid_q) ? err : out_err_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (clr_cnt) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_fire) begin
      if (out_err_q == 2'b01 && corr_cnt_q != CNT_MAX)   corr_cnt_d   = corr_cnt_q + 1'b1;
      if (out_err_q == 2'b10 && uncorr_cnt_q != CNT_MAX) uncorr_cnt_d = uncorr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 2'b00;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule
